// File: rtl/div_arbiter_if.sv
// Requester, response and divider-side signals of the two-port divider arbiter.
// slave: arbiter view; master: requesters plus divider view.
interface div_arbiter_if;
  logic        rq0_valid, rq0_ready, rq0_divw, rq0_signed, rq0_flush;
  logic [63:0] rq0_a, rq0_b;
  logic        rq1_valid, rq1_ready, rq1_divw, rq1_signed, rq1_flush;
  logic [63:0] rq1_a, rq1_b;
  logic        rs0_valid, rs0_ready;
  logic [63:0] rs0_quot, rs0_rem;
  logic        rs1_valid, rs1_ready;
  logic [63:0] rs1_quot, rs1_rem;
  logic        dv_valid, dv_divw, dv_signed, dv_flush, dv_ready;
  logic [63:0] dv_dividend, dv_divisor, dv_quot, dv_rem;

  modport slave (
    input  rq0_valid, rq0_divw, rq0_signed, rq0_flush, rq0_a, rq0_b,
    input  rq1_valid, rq1_divw, rq1_signed, rq1_flush, rq1_a, rq1_b,
    input  rs0_ready, rs1_ready, dv_ready, dv_quot, dv_rem,
    output rq0_ready, rq1_ready,
    output rs0_valid, rs0_quot, rs0_rem, rs1_valid, rs1_quot, rs1_rem,
    output dv_valid, dv_divw, dv_signed, dv_dividend, dv_divisor, dv_flush
  );

  modport master (
    output rq0_valid, rq0_divw, rq0_signed, rq0_flush, rq0_a, rq0_b,
    output rq1_valid, rq1_divw, rq1_signed, rq1_flush, rq1_a, rq1_b,
    output rs0_ready, rs1_ready, dv_ready, dv_quot, dv_rem,
    input  rq0_ready, rq1_ready,
    input  rs0_valid, rs0_quot, rs0_rem, rs1_valid, rs1_quot, rs1_rem,
    input  dv_valid, dv_divw, dv_signed, dv_dividend, dv_divisor, dv_flush
  );
endinterface

// File: rtl/div_arbiter.sv
// Shares one iterative divider between two requesters with round-robin arbitration;
// divide-by-zero and signed overflow are resolved locally without launching the divider.
module div_arbiter (
  input logic         clk,
  input logic         rst,
  div_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d, prio_q, prio_d, divw_q, divw_d;
  logic [63:0] quot_q, quot_d, rem_q, rem_d;

  logic        elig0, elig1, any_elig, win;
  logic        w_divw, w_signed;
  logic [63:0] w_a, w_b, sp_q, sp_r;
  logic        div0, ovf, special, idle_go, accept, own_flush, own_rs_ready;

  function automatic logic [63:0] fix_width(input logic divw, input logic [63:0] v);
    return divw ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  always_comb begin
    elig0    = bus.rq0_valid & ~bus.rq0_flush;
    elig1    = bus.rq1_valid & ~bus.rq1_flush;
    any_elig = elig0 | elig1;
    win      = (elig0 & elig1) ? prio_q : elig1;
    w_divw   = win ? bus.rq1_divw   : bus.rq0_divw;
    w_signed = win ? bus.rq1_signed : bus.rq0_signed;
    w_a      = win ? bus.rq1_a      : bus.rq0_a;
    w_b      = win ? bus.rq1_b      : bus.rq0_b;
    // Special cases are judged at the operation width, so 32-bit ops ignore upper bits.
    if (w_divw) begin
      div0 = (w_b[31:0] == '0);
      ovf  = w_signed & (w_a[31:0] == 32'h8000_0000) & (w_b[31:0] == '1);
    end else begin
      div0 = (w_b == '0);
      ovf  = w_signed & (w_a == {1'b1, 63'd0}) & (w_b == '1);
    end
    special      = div0 | ovf;
    sp_q         = div0 ? '1 : w_a;
    sp_r         = div0 ? w_a : '0;
    idle_go      = (state_q == IDLE) & any_elig & ~rst;
    accept       = idle_go & (special | bus.dv_ready);
    own_flush    = owner_q ? bus.rq1_flush : bus.rq0_flush;
    own_rs_ready = owner_q ? bus.rs1_ready : bus.rs0_ready;
  end

  assign bus.rq0_ready   = accept & ~win;
  assign bus.rq1_ready   = accept & win;
  assign bus.dv_valid    = idle_go & ~special & bus.dv_ready;
  assign bus.dv_divw     = w_divw;
  assign bus.dv_signed   = w_signed;
  assign bus.dv_dividend = w_a;
  assign bus.dv_divisor  = w_b;
  assign bus.dv_flush    = (state_q == BUSY) & own_flush & ~rst;
  assign bus.rs0_valid   = (state_q == RESP) & ~owner_q & ~bus.rq0_flush;
  assign bus.rs1_valid   = (state_q == RESP) & owner_q & ~bus.rq1_flush;
  assign bus.rs0_quot    = quot_q;
  assign bus.rs0_rem     = rem_q;
  assign bus.rs1_quot    = quot_q;
  assign bus.rs1_rem     = rem_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    divw_d  = divw_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = win;
          prio_d  = ~win;
          divw_d  = w_divw;
          if (special) begin
            quot_d  = fix_width(w_divw, sp_q);
            rem_d   = fix_width(w_divw, sp_r);
            state_d = RESP;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // A flush landing together with dv_ready still discards the result.
        if (own_flush) begin
          state_d = IDLE;
        end else if (bus.dv_ready) begin
          quot_d  = fix_width(divw_q, bus.dv_quot);
          rem_d   = fix_width(divw_q, bus.dv_rem);
          state_d = RESP;
        end
      end
      RESP: begin
        if (own_flush || own_rs_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      divw_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      divw_q  <= divw_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end
endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural iterative divider
// (65/33 busy cycles after launch, result visible one cycle before dv_ready).
module tb_div_arbiter;
  logic clk;
  logic rst;
  div_arbiter_if bus ();

  div_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Divider model
  int          launches = 0;
  int          cnt = 0, recover = 0;
  logic        s_rst, s_flush, s_launch, s_divw, s_sgn;
  logic [63:0] s_a, s_b, mq, mr;
  logic signed [63:0] sa, sb;
  logic signed [31:0] sa32, sb32;
  logic [31:0] ua32, ub32;

  initial begin
    bus.dv_ready = 1'b0;
    bus.dv_quot  = '0;
    bus.dv_rem   = '0;
    mq = '0;
    mr = '0;
    forever begin
      @(negedge clk);
      s_rst    = rst;
      s_flush  = bus.dv_flush;
      s_launch = bus.dv_valid & bus.dv_ready;
      s_divw   = bus.dv_divw;
      s_sgn    = bus.dv_signed;
      s_a      = bus.dv_dividend;
      s_b      = bus.dv_divisor;
      @(posedge clk);
      #1;
      if (s_rst || s_flush) begin
        bus.dv_ready = 1'b0;
        cnt = 0;
        recover = 3;
      end else if (s_launch) begin
        launches++;
        bus.dv_ready = 1'b0;
        cnt = s_divw ? 33 : 65;
        if (s_divw) begin
          if (s_sgn) begin
            sa32 = s_a[31:0]; sb32 = s_b[31:0];
            ua32 = sa32 / sb32; ub32 = sa32 % sb32;
          end else begin
            ua32 = s_a[31:0] / s_b[31:0]; ub32 = s_a[31:0] % s_b[31:0];
          end
          mq = {32'd0, ua32};
          mr = {32'd0, ub32};
        end else if (s_sgn) begin
          sa = s_a; sb = s_b;
          mq = sa / sb; mr = sa % sb;
        end else begin
          mq = s_a / s_b; mr = s_a % s_b;
        end
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 1) begin
          bus.dv_quot = mq;
          bus.dv_rem  = mr;
        end
        if (cnt == 0) bus.dv_ready = 1'b1;
      end else if (recover > 0) begin
        recover--;
        if (recover == 0) bus.dv_ready = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_rq(input int n, input logic v, input logic dw, input logic sg,
                        input logic [63:0] a, input logic [63:0] b);
    if (n == 0) begin
      bus.rq0_valid = v; bus.rq0_divw = dw; bus.rq0_signed = sg; bus.rq0_a = a; bus.rq0_b = b;
    end else begin
      bus.rq1_valid = v; bus.rq1_divw = dw; bus.rq1_signed = sg; bus.rq1_a = a; bus.rq1_b = b;
    end
  endtask

  function automatic logic rq_rdy(input int n);
    return (n == 0) ? bus.rq0_ready : bus.rq1_ready;
  endfunction

  function automatic logic rs_vld(input int n);
    return (n == 0) ? bus.rs0_valid : bus.rs1_valid;
  endfunction

  // Present an op, wait for acceptance, drop valid, then measure latency and check result.
  task automatic issue(input int n, input logic dw, input logic sg, input logic [63:0] a,
                       input logic [63:0] b, input int maxw, input int elat,
                       input logic [63:0] eq, input logic [63:0] er, input string tag);
    int k;
    int lat;
    set_rq(n, 1'b1, dw, sg, a, b);
    #1;
    k = 0;
    while (!rq_rdy(n) && k < 200) begin tick(); #1; k++; end
    chk({tag, "_acc"}, 64'(k <= maxw), 64'd1);
    tick();
    set_rq(n, 1'b0, dw, sg, a, b);
    #1;
    lat = 1;
    while (!rs_vld(n) && lat < 200) begin tick(); #1; lat++; end
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_quot"}, (n == 0) ? bus.rs0_quot : bus.rs1_quot, eq);
    chk({tag, "_rem"}, (n == 0) ? bus.rs0_rem : bus.rs1_rem, er);
    chk({tag, "_other"}, 64'(rs_vld(1 - n)), 64'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, k, lat, who;
    logic [63:0] hq, hr;
    logic seen;
    rst = 1'b1;
    set_rq(0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_rq(1, 1'b0, 1'b0, 1'b0, '0, '0);
    bus.rq0_flush = 1'b0; bus.rq1_flush = 1'b0;
    bus.rs0_ready = 1'b1; bus.rs1_ready = 1'b1;
    repeat (3) tick();
    #1;
    chk("rst_rs0_valid", 64'(bus.rs0_valid), 64'd0);
    chk("rst_rs1_valid", 64'(bus.rs1_valid), 64'd0);
    chk("rst_dv_valid", 64'(bus.dv_valid), 64'd0);
    chk("rst_quot", bus.rs0_quot, 64'd0);
    rst = 1'b0;
    tick();

    // Special cases proceed while the divider is still not ready after reset
    l0 = launches;
    issue(0, 1'b0, 1'b0, 64'd5, 64'd0, 0, 1, '1, 64'd5, "div0_64");
    issue(1, 1'b0, 1'b1, 64'h8000_0000_0000_0000, '1, 0, 1,
          64'h8000_0000_0000_0000, 64'd0, "ovf_64");
    issue(1, 1'b1, 1'b0, 64'h1234_5678_8765_4321, 64'hABCD_0000_0000_0000, 0, 1,
          '1, 64'hFFFF_FFFF_8765_4321, "div0_32");
    issue(0, 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0, 1,
          64'hFFFF_FFFF_8000_0000, 64'd0, "ovf_32");
    chk("no_launch_special", 64'(launches - l0), 64'd0);

    issue(0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 200, 67,
          64'hFFFF_FFFF_FFFF_FFFD, '1, "s64");
    issue(1, 1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000, 64'd2, 200, 35,
          64'h0000_0000_4000_0000, 64'd0, "u32");
    issue(1, 1'b0, 1'b0, '1, 64'h10, 200, 67, 64'h0FFF_FFFF_FFFF_FFFF, 64'hF, "u64");

    // Round-robin with both requesters continuously valid
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    set_rq(0, 1'b1, 1'b1, 1'b0, 64'd100, 64'd7);
    set_rq(1, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    for (int g = 0; g < 4; g++) begin
      #1;
      k = 0;
      while (!(bus.rq0_ready | bus.rq1_ready) && k < 200) begin tick(); #1; k++; end
      chk("rr_one_ready", 64'(bus.rq0_ready & bus.rq1_ready), 64'd0);
      who = bus.rq1_ready ? 1 : 0;
      chk("rr_grant", 64'(who), 64'(g % 2));
      tick(); #1;
      lat = 1;
      while (!(bus.rs0_valid | bus.rs1_valid) && lat < 200) begin tick(); #1; lat++; end
      chk("rr_lat", 64'(lat), 64'd35);
      chk("rr_rs_owner", 64'(rs_vld(g % 2)), 64'd1);
      chk("rr_rs_other", 64'(rs_vld(1 - (g % 2))), 64'd0);
      chk("rr_quot", bus.rs0_quot, (g % 2 == 0) ? 64'd14 : 64'hFFFF_FFFF_FFFF_FFFD);
      chk("rr_rem", bus.rs0_rem, (g % 2 == 0) ? 64'd2 : '1);
      tick();
    end
    set_rq(0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_rq(1, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();

    // Flush of the owner while the divider runs
    set_rq(0, 1'b1, 1'b0, 1'b0, 64'd1000, 64'd3);
    #1;
    k = 0;
    while (!bus.rq0_ready && k < 200) begin tick(); #1; k++; end
    chk("fl_acc", 64'(bus.rq0_ready), 64'd1);
    tick();
    set_rq(0, 1'b0, 1'b0, 1'b0, 64'd1000, 64'd3);
    repeat (9) tick();
    bus.rq0_flush = 1'b1;
    set_rq(1, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000, 64'd2);
    #1;
    chk("fl_dv_flush", 64'(bus.dv_flush), 64'd1);
    chk("fl_rq1_wait", 64'(bus.rq1_ready), 64'd0);
    tick();
    bus.rq0_flush = 1'b0;
    #1;
    chk("fl_no_rs0", 64'(bus.rs0_valid), 64'd0);
    chk("fl_flush_pulse", 64'(bus.dv_flush), 64'd0);
    chk("fl_stall", 64'(bus.rq1_ready), 64'd0);
    issue(1, 1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000, 64'd2, 200, 35,
          64'h0000_0000_4000_0000, 64'd0, "fl_next");

    // Back-pressure in RESP
    bus.rs0_ready = 1'b0;
    set_rq(0, 1'b1, 1'b0, 1'b0, 64'd5, 64'd0);
    #1;
    chk("bp_acc", 64'(bus.rq0_ready), 64'd1);
    tick();
    set_rq(0, 1'b0, 1'b0, 1'b0, 64'd5, 64'd0);
    set_rq(1, 1'b1, 1'b0, 1'b1, 64'h8000_0000_0000_0000, '1);
    #1;
    hq = bus.rs0_quot;
    hr = bus.rs0_rem;
    chk("bp_quot", hq, '1);
    chk("bp_rem", hr, 64'd5);
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid", 64'(bus.rs0_valid), 64'd1);
      chk("bp_stable", {bus.rs0_quot[31:0], bus.rs0_rem[31:0]}, {hq[31:0], hr[31:0]});
      chk("bp_rq1_hold", 64'(bus.rq1_ready), 64'd0);
      chk("bp_rs1", 64'(bus.rs1_valid), 64'd0);
      tick(); #1;
    end
    bus.rs0_ready = 1'b1;
    tick();
    issue(1, 1'b0, 1'b1, 64'h8000_0000_0000_0000, '1, 0, 1,
          64'h8000_0000_0000_0000, 64'd0, "bp_next");

    // Reset in the middle of a divide
    set_rq(0, 1'b1, 1'b0, 1'b0, 64'd50, 64'd5);
    #1;
    k = 0;
    while (!bus.rq0_ready && k < 200) begin tick(); #1; k++; end
    chk("rb_acc", 64'(bus.rq0_ready), 64'd1);
    tick();
    set_rq(0, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rb_outs", {59'd0, bus.rq0_ready, bus.rq1_ready, bus.rs0_valid, bus.rs1_valid,
                    bus.dv_valid}, 64'd0);
    chk("rb_flush", 64'(bus.dv_flush), 64'd0);
    chk("rb_quot", bus.rs0_quot, 64'd0);
    seen = 1'b0;
    repeat (80) begin
      tick(); #1;
      seen = seen | bus.rs0_valid | bus.rs1_valid;
    end
    chk("rb_no_resp", 64'(seen), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
